// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one data-memory port.
// Unaligned (size 2) accesses are optionally sequenced as four byte accesses.
module mem_port_arbiter #(
  parameter bit          SPLIT_EN = 1'b1,
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        we0,
  input  logic        we1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SPLIT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;

  logic        sel;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_size;
  logic        w_we;
  logic        reject;
  logic [7:0]  lane_byte;
  logic [1:0]  k_next;

  // Requester handshake: reqN is held with its addr/wdata/size/we until the
  // one-cycle doneN pulse; everything is latched at grant, so later changes
  // on the requester side are ignored until the next grant.
  always_comb begin
    sel     = (req0 && req1) ? ~last_grant_q : req1;
    w_addr  = sel ? addr1  : addr0;
    w_wdata = sel ? wdata1 : wdata0;
    w_size  = sel ? size1  : size0;
    w_we    = sel ? we1    : we0;
    reject  = (w_addr[31:16] != MEM_ADDR)
           || (w_size == 2'd3 && w_addr[1:0] != 2'b00)
           || (w_size == 2'd1 && w_addr[0])
           || (w_size == 2'd2 && !SPLIT_EN);
    lane_byte = mem_rdata[{mem_addr_q[1:0], 3'b000} +: 8];
    k_next    = k_q + 2'd1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    we_d         = we_q;
    err_d        = err_q;
    k_d          = k_q;
    rbuf_d       = rbuf_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_size_d   = mem_size_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          last_grant_d = sel;
          port_d       = sel;
          addr_d       = w_addr;
          wdata_d      = w_wdata;
          size_d       = w_size;
          we_d         = w_we;
          err_d        = reject;
          k_d          = 2'd0;
          if (reject) begin
            state_d = S_DONE;
          end else if (w_size == 2'd2) begin
            state_d     = S_SPLIT;
            mem_addr_d  = w_addr;
            mem_size_d  = 2'd0;
            mem_wdata_d = {24'h0, w_wdata[7:0]};
          end else begin
            state_d     = S_ACC;
            mem_addr_d  = w_addr;
            mem_size_d  = w_size;
            mem_wdata_d = w_wdata;
          end
        end
      end

      S_ACC: begin
        if (!we_q) begin
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
        state_d = S_DONE;
      end

      S_SPLIT: begin
        // Bytes 0..2 collect in rbuf so the port's rdata only changes at done.
        if (k_q == 2'd3) begin
          if (!we_q) begin
            if (port_q) rdata1_d = {lane_byte, rbuf_q};
            else        rdata0_d = {lane_byte, rbuf_q};
          end
          state_d = S_DONE;
        end else begin
          if (!we_q) rbuf_d[{k_q, 3'b000} +: 8] = lane_byte;
          k_d         = k_next;
          mem_addr_d  = addr_q + {30'h0, k_next};
          mem_wdata_d = {24'h0, wdata_q[{k_next, 3'b000} +: 8]};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      size_q       <= 2'd0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      k_q          <= 2'd0;
      rbuf_q       <= 24'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_size_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      err_q        <= err_d;
      k_q          <= k_d;
      rbuf_q       <= rbuf_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
    end
  end

  // Write strobe is gated by reset so an access cut short never commits.
  always_comb begin
    done0     = (state_q == S_DONE) && !port_q;
    done1     = (state_q == S_DONE) && port_q;
    err0      = done0 && err_q;
    err1      = done1 && err_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_size  = mem_size_q;
    mem_we    = (state_q == S_ACC || state_q == S_SPLIT) && we_q && !reset;
    mem_re    = (state_q == S_ACC || state_q == S_SPLIT) && !we_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the single data-memory port (4 KB, byte-lane, combinational read, write on posedge, sizes 0=byte, 1=half, 2=unaligned, 3=word). Port 0 is the CPU load/store unit and port 1 is the debug/DMA loader. Requests are granted round-robin and each is driven onto the memory from registers. Unaligned accesses (size 2), which the memory rejects, are split into four byte accesses.

Parameters:
SPLIT_EN, 1, 1 = sequence size-2 accesses as 4 byte accesses; 0 = reject them with err.
MEM_ADDR, 16'h1000, required value of addr[31:16]; any other value gives err, with no memory access.

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
req0 / req1  in  1  access request; held stable with its addr/wdata/size/we until done
addr0 / addr1  in  32  byte address
wdata0 / wdata1  in  32  write data, little-endian
size0 / size1  in  2  access size, same encoding as the memory
we0 / we1  in  1  1 = write, 0 = read
done0 / done1  out  1  one-cycle completion pulse
err0 / err1  out  1  one-cycle pulse with done: access rejected, memory untouched
rdata0 / rdata1  out  32  read data, valid while done is high, held until the next done on that port
mem_addr  out  32  to memory addr_in
mem_wdata  out  32  to memory data_in
mem_size  out  2  to memory size_in
mem_we  out  1  to memory we_in
mem_re  out  1  to memory re_in
mem_rdata  in  32  from memory data_out (combinational)

Behaviour:
- Reset (synchronous): state = IDLE, last_grant = 1 (so port 0 wins the first tie), rdata regs = 0.
- Reset values: done/err = 0, mem_we = mem_re = 0, mem_addr/mem_wdata/mem_size = 0.
- mem_we is forced to 0 in any cycle where reset is high.
- FSM states:
  - IDLE: if any req is high, pick the winner. If both are high, grant the port != last_grant. Latch the winner's addr, wdata, size, we, and port id; set last_grant = winner.
    - Rejection check: addr[31:16] != MEM_ADDR, or size 3 with addr[1:0] != 0, or size 1 with addr[0] != 0, or size 2 with SPLIT_EN = 0. If rejected, go to DONE with err set.
    - Otherwise go to ACC when size != 2, or SPLIT when size = 2 (k = 0).
  - ACC: drive the latched addr, wdata, and size; mem_we = we, mem_re = !we. At the posedge ending ACC, capture rdata = mem_rdata if a read. Go to DONE.
  - SPLIT: byte k (k = 0..3).
    - Drive mem_addr = addr + k (32-bit add; the carry propagates into addr[31:16]; the MEM_ADDR check applies to the base addr only), mem_size = 0, mem_wdata[7:0] = wdata[8k+7:8k].
    - On a read, capture rdata[8k+7:8k] = mem_rdata byte lane (addr+k)[1:0].
    - k = 3 goes to DONE.
  - DONE: pulse done (and err if flagged) on the latched port only, for exactly 1 cycle. No memory access. Go to IDLE.
- Latency from req sampled in IDLE at cycle T: aligned access, done at T+2; split access, done at T+5; rejected access, done at T+1.
- Throughput: a new req is accepted at the earliest in the cycle after DONE, so back-to-back aligned accesses take 3 cycles each.
- The losing requester waits; no request is dropped. Strict alternation when both ports request continuously.
- A req deasserted mid-access is ignored; the latched access completes. Requester-side changes to addr/wdata after the grant have no effect.
- Outside ACC/SPLIT, mem_we = mem_re = 0; mem_addr/mem_wdata/mem_size hold their last driven values.
- Reset mid-access: return to IDLE immediately, no done pulse; a write whose posedge coincides with reset is not performed.

Test Plan:
- Reset, then port 0 word write addr 0x10000008 data 0xDEADBEEF, then a word read of the same address -> mem_we high for exactly 1 cycle; done0 at T+2 for each access; rdata0 = 0xDEADBEEF.
- req0 and req1 both held continuously with word reads -> grant order 0,1,0,1; each done 3 cycles apart; no done pulse ever on both ports in the same cycle.
- Port 1 unaligned write addr 0x10000011 data 0x44332211 (size 2) -> four byte writes at 0x11, 0x12, 0x13, 0x14; done1 at T+5; a size-2 read of the same address returns 0x44332211.
- Port 0 word write addr 0x20000000; then size 3 at 0x10000002 -> each gives done0 and err0 at T+1, mem_we stays 0, and a read of 0x10000000 is unchanged.
- SPLIT_EN = 0 with a size-2 read -> err pulse. Separately, reset asserted during SPLIT k = 1 -> FSM returns to IDLE, no done, only byte 0 is written.
- Port 1 halfword read at 0x10000006 while port 0 is idle, then port 0 request -> port 1 served first, then port 0 (last_grant = 1).
